reg_port_arbiter: RTL

Two-requester arbiter sharing the single command port of the 16×32 register memory (2 read ports, 1 write port) between the core execute/writeback stage (requester 0) and the filter coefficient loader (requester 1). It runs a round-robin ownership state machine with a bounded burst length. It drives the register memory's active-low enables, and routes registered read data back to the requester that issued the read.

---
 rtl/reg_port_arbiter_if.sv | 34 +++
 rtl/reg_port_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/reg_port_arbiter_if.sv
// rtl/reg_port_arbiter_if.sv - requester, arbiter and register-memory signals of the shared RF port
interface reg_port_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 32
);
    logic          req0, req1;
    logic          re_a0, re_a1, re_b0, re_b1;
    logic          we0, we1;
    logic [AW-1:0] dir_a0, dir_a1, dir_b0, dir_b1, dir_w0, dir_w1;
    logic [DW-1:0] di0, di1;
    logic          gnt0, gnt1;
    logic          rvalid0, rvalid1;
    logic [DW-1:0] rdata_a, rdata_b;
    logic [AW-1:0] DirA, DirB, Dir_WRA;
    logic [DW-1:0] DI;
    logic          RE_A, RE_B, reg_WE;
    logic [DW-1:0] DataA, DataB;

    modport slave (
        input  req0, req1, re_a0, re_a1, re_b0, re_b1, we0, we1,
        input  dir_a0, dir_a1, dir_b0, dir_b1, dir_w0, dir_w1, di0, di1,
        input  DataA, DataB,
        output gnt0, gnt1, rvalid0, rvalid1, rdata_a, rdata_b,
        output DirA, DirB, Dir_WRA, DI, RE_A, RE_B, reg_WE
    );

    modport master (
        output req0, req1, re_a0, re_a1, re_b0, re_b1, we0, we1,
        output dir_a0, dir_a1, dir_b0, dir_b1, dir_w0, dir_w1, di0, di1,
        output DataA, DataB,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata_a, rdata_b,
        input  DirA, DirB, Dir_WRA, DI, RE_A, RE_B, reg_WE
    );
endinterface

// File: rtl/reg_port_arbiter.sv
// rtl/reg_port_arbiter.sv - round-robin, burst-bounded owner of the single register-memory command port
module reg_port_arbiter #(
    parameter int AW        = 4,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    reg_port_arbiter_if.slave bus
);
    localparam int          CW    = $clog2(MAX_BURST + 1);
    localparam logic [CW:0] MAX_B = (CW+1)'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state_q, state_d, oth_state;
    logic          last_q, last_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic [CW:0]   burst_inc;
    logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic          gnt0, gnt1, own_req, oth_req;
    logic          re_a, re_b, we;
    logic [AW-1:0] dir_a, dir_b, dir_w;
    logic [DW-1:0] di;

    assign gnt0      = (state_q == OWN0) && bus.req0;
    assign gnt1      = (state_q == OWN1) && bus.req1;
    assign burst_inc = {1'b0, burst_cnt_q} + (CW+1)'(1);

    always_comb begin
        own_req   = bus.req0;
        oth_req   = bus.req1;
        oth_state = OWN1;
        if (state_q == OWN1) begin
            own_req   = bus.req1;
            oth_req   = bus.req0;
            oth_state = OWN0;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 && bus.req1) state_d = last_q ? OWN0 : OWN1;
                else if (bus.req0)        state_d = OWN0;
                else if (bus.req1)        state_d = OWN1;
            end
            OWN0, OWN1: begin
                // >= also hands over when a lone owner's count already saturated
                if (!own_req)                          state_d = oth_req ? oth_state : IDLE;
                else if (oth_req && burst_inc >= MAX_B) state_d = oth_state;
                else if (burst_inc <= MAX_B)           burst_cnt_d = burst_inc[CW-1:0];
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q && state_d != IDLE) begin
            burst_cnt_d = '0;
            last_d      = (state_d == OWN1);
        end
        rvalid0_d = gnt0 && (bus.re_a0 || bus.re_b0);
        rvalid1_d = gnt1 && (bus.re_a1 || bus.re_b1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            burst_cnt_q <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
        end
    end

    // Memory controls decode straight from state so an async reset kills a pending negedge write
    always_comb begin
        re_a  = 1'b0;
        re_b  = 1'b0;
        we    = 1'b0;
        dir_a = '0;
        dir_b = '0;
        dir_w = '0;
        di    = '0;
        if (gnt0) begin
            re_a  = bus.re_a0;
            re_b  = bus.re_b0;
            we    = bus.we0;
            dir_a = bus.dir_a0;
            dir_b = bus.dir_b0;
            dir_w = bus.dir_w0;
            di    = bus.di0;
        end else if (gnt1) begin
            re_a  = bus.re_a1;
            re_b  = bus.re_b1;
            we    = bus.we1;
            dir_a = bus.dir_a1;
            dir_b = bus.dir_b1;
            dir_w = bus.dir_w1;
            di    = bus.di1;
        end
    end

    assign bus.gnt0    = gnt0;
    assign bus.gnt1    = gnt1;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rdata_a = bus.DataA;
    assign bus.rdata_b = bus.DataB;
    assign bus.RE_A    = !re_a;
    assign bus.RE_B    = !re_b;
    assign bus.reg_WE  = !we;
    assign bus.DirA    = dir_a;
    assign bus.DirB    = dir_b;
    assign bus.Dir_WRA = dir_w;
    assign bus.DI      = di;
endmodule
